movi_exec_fsm: RTL and testbench
================================

# movi_exec_fsm

Parametrised execution FSM for the MOVI (move-immediate) instruction in the microcontroller datapath. It sits beside the other per-opcode control FSMs and is triggered by the instruction register once fetch (`if_active`) ends. It sequences PC increment, bus arbitration, and driving the extended immediate onto the shared bus. It then produces a one-hot register-load strobe and a `done` pulse, adding bus-grant handshaking, timeout and illegal-destination error reporting.

## Interface
Parameters:
- `DATA_W`, 16, bus/register width; must be ≥ `IMM_W`.
- `IMM_W`, 6, immediate field width, `instr[IMM_W-1:0]`.
- `NUM_REGS`, 6, number of loadable registers; `reg_load` width.
- `OPCODE`, 4'b0111, value of `instr[15:12]` that selects MOVI.
- `WAIT_MAX`, 15, maximum cycles waiting for `bus_gnt`; must be ≥ 1.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `if_active`  in  1  fetch in progress; synchronous abort to IDLE.
- `instr`  in  16  instruction word: opcode `[15:12]`, destination `[11:6]`, immediate `[IMM_W-1:0]`.
- `bus_gnt`  in  1  bus grant from arbiter.
- `pc_inc`  out  1  PC increment strobe.
- `bus_req`  out  1  bus request.
- `imm_drive`  out  1  tri-state/mux enable for `imm_bus` onto shared bus.
- `imm_bus`  out  DATA_W  extended immediate.
- `reg_load`  out  NUM_REGS  one-hot register load strobe.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  valid with `done`: timeout or illegal destination.

## Operation
- States: IDLE, INC, REQ, SETUP, LOAD, DONE, HOLD.
- IDLE→INC when `instr[15:12]==OPCODE` and `!if_active`. On this edge, latch the destination (6 b) and the extended immediate. Later `instr` changes are ignored until IDLE.
- INC: `pc_inc=1`, one cycle, then REQ.
- REQ: `bus_req=1`.
  - `bus_gnt` sampled high → SETUP.
  - Else the wait counter increments. When the counter reaches `WAIT_MAX`, go to DONE with the error flag set.
- SETUP: `bus_req=1`, `imm_drive=1`, `imm_bus`=latched value, then LOAD.
- LOAD: as SETUP, plus `reg_load[dest]=1`. If dest ≥ `NUM_REGS`, `reg_load` stays 0 and the error flag is set. Next state is DONE.
- DONE: `done=1`, `err`=error flag, one cycle, then HOLD.
- HOLD: all outputs 0 until `if_active`.
- `if_active` high forces IDLE at the next edge from any state; the wait counter and error flag are cleared. Abort during LOAD still completes that cycle's strobe.
- The arbiter holds `bus_gnt` while `bus_req` is high. A grant drop in SETUP/LOAD is ignored.
- Outputs are a Moore decode of the state register plus the latched fields; no output depends combinationally on `instr` or `bus_gnt`.
- `imm_bus` is 0 outside SETUP/LOAD.

## Timing
- Reset: state IDLE. All outputs 0, including `pc_inc`, `bus_req`, `imm_drive`, `imm_bus`, `reg_load`, `done` and `err`. Latches and counter are 0.
- Trigger edge T: INC during T+1, REQ from T+2. With an immediate grant: SETUP T+3, LOAD T+4, DONE T+5.
- Each extra grant-wait cycle adds one cycle. A timeout puts DONE at T+2+`WAIT_MAX` and produces no SETUP/LOAD.
- `rst` mid-operation returns to IDLE immediately (asynchronous) and clears all outputs.

## Configuration
- `MOVI_SIGN_EXT_EN` defined: immediate is sign-extended, `imm[IMM_W-1]` replicated to `DATA_W`.
- Not defined: immediate is zero-extended.

## Structure
- Package `movi_pkg`: state enum, default `OPCODE`, instruction field position constants.
- Sub-module `movi_imm_ext`: combinational `IMM_W`→`DATA_W` extender, honouring `MOVI_SIGN_EXT_EN`.

## Test plan
- `instr`=16'h70C5 (dest 3, imm 5), `bus_gnt` tied 1 → `pc_inc` at T+1; `imm_drive` T+3..T+4 with `imm_bus`=16'h0005; `reg_load`=6'b001000 at T+4; `done` at T+5 with `err`=0.
- `bus_gnt` low 4 cycles, then high → SETUP delayed 4 cycles; same load/done values.
- `bus_gnt` never high, `WAIT_MAX`=15 → `done`+`err` at T+17; `reg_load` and `imm_drive` never asserted.
- `instr`=16'h71BF (dest 6, illegal, imm 6'h3F) → `reg_load`=0, `done`+`err`=1. `imm_bus`=16'hFFFF with the macro, 16'h003F without.
- `if_active` pulsed during REQ → IDLE next edge, no `done`. Asynchronous `rst` during SETUP → all outputs 0 immediately.
- Opcode ≠ 4'b0111 held with `if_active`=0 → stays IDLE, all outputs 0.

Source files
------------

// File: rtl/movi_pkg.sv
// rtl/movi_pkg.sv - shared state encoding, default opcode and instruction field positions for the MOVI executor
package movi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INC,
    ST_REQ,
    ST_SETUP,
    ST_LOAD,
    ST_DONE,
    ST_HOLD
  } movi_state_e;

  localparam int INSTR_W = 16;
  localparam logic [3:0] MOVI_OPCODE = 4'b0111;

  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int DEST_MSB = 11;
  localparam int DEST_LSB = 6;
  localparam int DEST_W   = DEST_MSB - DEST_LSB + 1;

endpackage

// File: rtl/movi_exec_fsm_if.sv
// rtl/movi_exec_fsm_if.sv - instruction, arbiter handshake and datapath strobes of the MOVI executor
interface movi_exec_fsm_if #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 6
);
  import movi_pkg::*;

  logic               if_active;
  logic [INSTR_W-1:0] instr;
  logic               bus_gnt;
  logic               pc_inc;
  logic               bus_req;
  logic               imm_drive;
  logic [DATA_W-1:0]  imm_bus;
  logic [NUM_REGS-1:0] reg_load;
  logic               done;
  logic               err;

  modport master (
    input  if_active, instr, bus_gnt,
    output pc_inc, bus_req, imm_drive, imm_bus, reg_load, done, err
  );

  modport slave (
    output if_active, instr, bus_gnt,
    input  pc_inc, bus_req, imm_drive, imm_bus, reg_load, done, err
  );

endinterface

// File: rtl/movi_imm_ext.sv
// rtl/movi_imm_ext.sv - immediate width extender; MOVI_SIGN_EXT_EN selects sign extension, else zero extension
module movi_imm_ext #(
  parameter int IMM_W  = 6,
  parameter int DATA_W = 16
) (
  input  logic [IMM_W-1:0]  imm,
  output logic [DATA_W-1:0] ext
);

`ifdef MOVI_SIGN_EXT_EN
  assign ext = DATA_W'($signed(imm));
`else
  assign ext = DATA_W'(imm);
`endif

endmodule

// File: rtl/movi_exec_fsm.sv
// rtl/movi_exec_fsm.sv - MOVI execution FSM: PC bump, bus arbitration, immediate drive and one-hot register load.
// Immediate extension mode follows MOVI_SIGN_EXT_EN (see movi_imm_ext).
module movi_exec_fsm
  import movi_pkg::*;
#(
  parameter int         DATA_W   = 16,
  parameter int         IMM_W    = 6,
  parameter int         NUM_REGS = 6,
  parameter logic [3:0] OPCODE   = MOVI_OPCODE,
  parameter int         WAIT_MAX = 15
) (
  input logic           clk,
  input logic           rst,
  movi_exec_fsm_if.master bus
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);

  movi_state_e         state_q, state_d;
  logic [DEST_W-1:0]   dest_q, dest_d;
  logic [DATA_W-1:0]   imm_q, imm_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   imm_ext;
  logic                dest_bad;

  logic                pc_inc_o, bus_req_o, imm_drive_o, done_o, err_o;
  logic [DATA_W-1:0]   imm_bus_o;
  logic [NUM_REGS-1:0] reg_load_o;

  movi_imm_ext #(.IMM_W(IMM_W), .DATA_W(DATA_W)) u_imm_ext (
    .imm (bus.instr[IMM_W-1:0]),
    .ext (imm_ext)
  );

  assign dest_bad = int'(dest_q) >= NUM_REGS;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dest_q  <= '0;
      imm_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      imm_q   <= imm_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    imm_d   = imm_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    // Fetch activity overrides everything; the Moore decode still finishes this cycle's strobes.
    if (bus.if_active) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.instr[OPC_MSB:OPC_LSB] == OPCODE) begin
            state_d = ST_INC;
            dest_d  = bus.instr[DEST_MSB:DEST_LSB];
            imm_d   = imm_ext;
            cnt_d   = '0;
            err_d   = 1'b0;
          end
        end
        ST_INC:   state_d = ST_REQ;
        ST_REQ: begin
          if (bus.bus_gnt) begin
            state_d = ST_SETUP;
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q + 1'b1 == CNT_W'(WAIT_MAX)) begin
              state_d = ST_DONE;
              err_d   = 1'b1;
            end
          end
        end
        ST_SETUP: state_d = ST_LOAD;
        ST_LOAD: begin
          state_d = ST_DONE;
          if (dest_bad) err_d = 1'b1;
        end
        ST_DONE:  state_d = ST_HOLD;
        ST_HOLD:  state_d = ST_HOLD;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    pc_inc_o    = 1'b0;
    bus_req_o   = 1'b0;
    imm_drive_o = 1'b0;
    imm_bus_o   = '0;
    reg_load_o  = '0;
    done_o      = 1'b0;
    err_o       = 1'b0;
    case (state_q)
      ST_INC: pc_inc_o = 1'b1;
      ST_REQ: bus_req_o = 1'b1;
      ST_SETUP: begin
        bus_req_o   = 1'b1;
        imm_drive_o = 1'b1;
        imm_bus_o   = imm_q;
      end
      ST_LOAD: begin
        bus_req_o   = 1'b1;
        imm_drive_o = 1'b1;
        imm_bus_o   = imm_q;
        for (int i = 0; i < NUM_REGS; i++) begin
          reg_load_o[i] = (int'(dest_q) == i);
        end
      end
      ST_DONE: begin
        done_o = 1'b1;
        err_o  = err_q;
      end
      default: ;
    endcase
  end

  assign bus.pc_inc    = pc_inc_o;
  assign bus.bus_req   = bus_req_o;
  assign bus.imm_drive = imm_drive_o;
  assign bus.imm_bus   = imm_bus_o;
  assign bus.reg_load  = reg_load_o;
  assign bus.done      = done_o;
  assign bus.err       = err_o;

endmodule

// File: tb/tb_movi_exec_fsm.sv
// tb/tb_movi_exec_fsm.sv - scoreboard bench for movi_exec_fsm; expected immediates follow MOVI_SIGN_EXT_EN
module tb_movi_exec_fsm;
  import movi_pkg::*;

  localparam int WAIT_MAX = 15;

  typedef struct packed {
    logic        pc_inc;
    logic        bus_req;
    logic        imm_drive;
    logic [15:0] imm_bus;
    logic [5:0]  reg_load;
    logic        done;
    logic        err;
  } out_t;

  typedef struct {
    string tag;
    out_t  val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  out_t obs;

  movi_exec_fsm_if #(.DATA_W(16), .NUM_REGS(6)) bus ();

  movi_exec_fsm #(
    .DATA_W(16), .IMM_W(6), .NUM_REGS(6), .OPCODE(4'b0111), .WAIT_MAX(WAIT_MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign obs = {bus.pc_inc, bus.bus_req, bus.imm_drive, bus.imm_bus,
                bus.reg_load, bus.done, bus.err};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check_eq(mon_e.tag, 32'(obs), 32'(mon_e.val));
    end
  end

  function automatic logic [15:0] ext_imm(input logic [5:0] imm);
`ifdef MOVI_SIGN_EXT_EN
    return {{10{imm[5]}}, imm};
`else
    return {10'b0, imm};
`endif
  endfunction

  // Timeline of one MOVI: n=1 is the cycle after the trigger edge, g grant-wait cycles.
  function automatic out_t exp_at(input int n, input int g, input logic [5:0] d, input logic [15:0] x);
    out_t r;
    logic to;
    int   w;
    r  = '0;
    to = (g >= WAIT_MAX);
    w  = to ? WAIT_MAX : g + 1;
    if (n == 1) r.pc_inc = 1'b1;
    else if (n >= 2 && n < 2 + w) r.bus_req = 1'b1;
    else if (!to && (n == 2 + w || n == 3 + w)) begin
      r.bus_req   = 1'b1;
      r.imm_drive = 1'b1;
      r.imm_bus   = x;
      if (n == 3 + w && d < 6) r.reg_load = 6'(1) << d;
    end
    if (n == (to ? 2 + w : 4 + w)) begin
      r.done = 1'b1;
      r.err  = to || (d >= 6);
    end
    return r;
  endfunction

  task automatic cyc(input string tag, input out_t e);
    exp_t x;
    x.tag = tag;
    x.val = e;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input string nm, input logic [15:0] ins, input int g, input int abort_n);
    logic [5:0]  d;
    logic [15:0] x;
    int          last;
    d    = ins[11:6];
    x    = ext_imm(ins[5:0]);
    last = (g >= WAIT_MAX) ? 2 + WAIT_MAX : 5 + g;
    bus.instr     = ins;
    bus.if_active = 1'b0;
    bus.bus_gnt   = (g == 0);
    cyc({nm, "_trig"}, '0);
    bus.instr = 16'hA5A5;
    for (int n = 1; n <= last + 2; n++) begin
      bus.bus_gnt = (g == 0) ? 1'b1 : (n == 2 + g);
      if (n == abort_n) bus.if_active = 1'b1;
      cyc($sformatf("%s_n%0d", nm, n), exp_at(n, g, d, x));
      if (n == abort_n) begin
        bus.if_active = 1'b0;
        break;
      end
    end
    bus.bus_gnt = 1'b0;
    cyc({nm, "_tail0"}, '0);
    cyc({nm, "_tail1"}, '0);
    bus.if_active = 1'b1;
    cyc({nm, "_fetch"}, '0);
    bus.if_active = 1'b0;
    cyc({nm, "_idle"}, '0);
  endtask

  initial begin
    bus.if_active = 1'b0;
    bus.instr     = 16'h0000;
    bus.bus_gnt   = 1'b0;
    #1;
    check_eq("reset_outputs", 32'(obs), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc("post_reset", '0);

    run_txn("gnt_now",  16'h70C5, 0, 0);
    run_txn("gnt_wait4", 16'h70C5, 4, 0);
    run_txn("abort_req", 16'h70C5, 10, 3);
    run_txn("timeout",  16'h70C5, 99, 0);
    run_txn("bad_dest", 16'h71BF, 0, 0);
    run_txn("dest0_neg", 16'h702A, 2, 0);
    run_txn("dest5",    16'h7155, 1, 0);

    bus.instr = 16'h60C5;
    for (int i = 0; i < 4; i++) cyc($sformatf("wrong_op_%0d", i), '0);

    // Asynchronous reset while driving the immediate.
    bus.instr   = 16'h70C5;
    bus.bus_gnt = 1'b1;
    cyc("rst_trig", '0);
    bus.instr = 16'h0000;
    cyc("rst_inc", exp_at(1, 0, 6'd3, ext_imm(6'h05)));
    cyc("rst_req", exp_at(2, 0, 6'd3, ext_imm(6'h05)));
    check_eq("setup_drive", 32'({bus.imm_drive, bus.imm_bus}), 32'({1'b1, 16'h0005}));
    #1;
    rst = 1'b1;
    #1;
    check_eq("async_rst_outputs", 32'(obs), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.bus_gnt = 1'b0;
    cyc("after_rst0", '0);
    cyc("after_rst1", '0);

    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
